// File: rtl/din_debounce_pkg.sv
// Shared definitions for the din_debounce slice: FSM state codes and the
// legal ranges of the block parameters.
package din_debounce_pkg;

    // FSM state codes
    localparam logic [1:0] ST_LOW    = 2'd0;
    localparam logic [1:0] ST_CHK_HI = 2'd1;
    localparam logic [1:0] ST_HIGH   = 2'd2;
    localparam logic [1:0] ST_CHK_LO = 2'd3;

    // Legal parameter ranges
    localparam int STABLE_CYCLES_MIN = 2;
    localparam int STABLE_CYCLES_MAX = 65535;
    localparam int SYNC_STAGES_MIN   = 2;
    localparam int SYNC_STAGES_MAX   = 4;

endpackage

// File: rtl/din_debounce_bit_sync.sv
// Multi-flop synchronizer bringing one asynchronous bit into the clk domain.
module bit_sync
    import din_debounce_pkg::*;
#(
    parameter int SYNC_STAGES = 2
) (
    input  logic clk,
    input  logic rst,
    input  logic d_i,
    output logic q_o
);

    logic [SYNC_STAGES-1:0] sync_q;

    // Shift the raw input through the chain; reset clears every stage.
    always_ff @(posedge clk) begin
        if (rst) begin
            sync_q <= '0;
        end else begin
            sync_q <= {sync_q[SYNC_STAGES-2:0], d_i};
        end
    end

    assign q_o = sync_q[SYNC_STAGES-1];

endmodule

// File: rtl/din_debounce.sv
// Debouncer: synchronizes a raw pin level and only accepts a new level once
// it has been seen for STABLE_CYCLES consecutive synchronized samples.
module din_debounce
    import din_debounce_pkg::*;
#(
    parameter int STABLE_CYCLES = 4,
    parameter int SYNC_STAGES   = 2
) (
    input  logic clk,
    input  logic rst,
    input  logic d,
    output logic q,
    output logic qbar,
    output logic rise,
    output logic fall,
    output logic busy
);

    localparam int CNT_W = $clog2(STABLE_CYCLES + 1);
    localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);
    localparam logic [CNT_W-1:0] CNT_DONE = CNT_W'(STABLE_CYCLES);

    logic             d_s;
    logic [1:0]       state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d, cnt_inc;
    logic             q_q, q_d;
    logic             rise_q, rise_d;
    logic             fall_q, fall_d;

    bit_sync #(
        .SYNC_STAGES(SYNC_STAGES)
    ) u_sync (
        .clk (clk),
        .rst (rst),
        .d_i (d),
        .q_o (d_s)
    );

    // cnt never exceeds STABLE_CYCLES-1 in a CHK state, so the increment fits.
    assign cnt_inc = cnt_q + CNT_ONE;

    // Next-state logic: qualify a candidate level, reject it on any glitch.
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        q_d     = q_q;
        rise_d  = 1'b0;
        fall_d  = 1'b0;
        case (state_q)
            ST_LOW: begin
                if (d_s) begin
                    state_d = ST_CHK_HI;
                    cnt_d   = CNT_ONE;
                end else begin
                    cnt_d   = '0;
                end
            end
            ST_CHK_HI: begin
                if (!d_s) begin
                    state_d = ST_LOW;
                    cnt_d   = '0;
                end else if (cnt_inc == CNT_DONE) begin
                    state_d = ST_HIGH;
                    cnt_d   = '0;
                    q_d     = 1'b1;
                    rise_d  = 1'b1;
                end else begin
                    cnt_d   = cnt_inc;
                end
            end
            ST_HIGH: begin
                if (!d_s) begin
                    state_d = ST_CHK_LO;
                    cnt_d   = CNT_ONE;
                end else begin
                    cnt_d   = '0;
                end
            end
            ST_CHK_LO: begin
                if (d_s) begin
                    state_d = ST_HIGH;
                    cnt_d   = '0;
                end else if (cnt_inc == CNT_DONE) begin
                    state_d = ST_LOW;
                    cnt_d   = '0;
                    q_d     = 1'b0;
                    fall_d  = 1'b1;
                end else begin
                    cnt_d   = cnt_inc;
                end
            end
            default: begin
                state_d = ST_LOW;
                cnt_d   = '0;
                q_d     = 1'b0;
            end
        endcase
    end

    // State, counter and outputs all move on the same edge; reset wins.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= ST_LOW;
            cnt_q   <= '0;
            q_q     <= 1'b0;
            rise_q  <= 1'b0;
            fall_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            q_q     <= q_d;
            rise_q  <= rise_d;
            fall_q  <= fall_d;
        end
    end

    assign q    = q_q;
    assign qbar = ~q_q;
    assign rise = rise_q;
    assign fall = fall_q;
    assign busy = (state_q == ST_CHK_HI) || (state_q == ST_CHK_LO);

endmodule

// File: tb/tb_din_debounce.sv
// Scoreboard bench for din_debounce: a window-based reference model predicts
// {q,qbar,rise,fall,busy} after every edge; a monitor compares the DUT.
module tb_din_debounce;

    localparam int N = 4;
    localparam int S = 2;

    typedef struct packed {
        logic [4:0] v;
        int         cyc;
    } exp_t;

    logic clk;
    logic rst;
    logic d;
    logic q, qbar, rise, fall, busy;

    int checks = 0;
    int passed = 0;
    int cycle  = 0;

    exp_t exp_q[$];

    // Reference model state: synchronizer delay line, last N synchronized
    // samples, and the accepted level.
    logic sm[S];
    logic win[$];
    logic mq;

    din_debounce #(
        .STABLE_CYCLES(N),
        .SYNC_STAGES  (S)
    ) dut (
        .clk  (clk),
        .rst  (rst),
        .d    (d),
        .q    (q),
        .qbar (qbar),
        .rise (rise),
        .fall (fall),
        .busy (busy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // The accepted level flips only when the last N synchronized samples all
    // differ from it; busy means the newest sample disagrees with the level.
    task automatic step(input logic dn, input logic rn);
        logic ds, all_diff, r, f, b;
        exp_t e;
        @(negedge clk);
        d   = dn;
        rst = rn;
        @(posedge clk);
        cycle++;
        if (rn) begin
            for (int i = 0; i < S; i++) sm[i] = 1'b0;
            win.delete();
            for (int i = 0; i < N; i++) win.push_back(1'b0);
            mq  = 1'b0;
            e.v = 5'b01000;
        end else begin
            ds = sm[S-1];
            for (int i = S - 1; i > 0; i--) sm[i] = sm[i-1];
            sm[0] = dn;
            win.push_back(ds);
            if (win.size() > N) void'(win.pop_front());
            all_diff = 1'b1;
            foreach (win[i]) if (win[i] == mq) all_diff = 1'b0;
            r = 1'b0;
            f = 1'b0;
            if (all_diff) begin
                mq = ~mq;
                r  = mq;
                f  = ~mq;
            end
            b   = (ds != mq);
            e.v = {mq, ~mq, r, f, b};
        end
        e.cyc = cycle;
        exp_q.push_back(e);
    endtask

    // Monitor: compare everything the scoreboard expects for this edge.
    initial begin
        exp_t e;
        logic [4:0] act;
        forever begin
            @(posedge clk);
            #1;
            while (exp_q.size() > 0) begin
                e   = exp_q.pop_front();
                act = {q, qbar, rise, fall, busy};
                checks++;
                if (act === e.v) begin
                    passed++;
                end else begin
                    $display("FAIL outs@cycle%0d: q/qbar/rise/fall/busy got %b expected %b",
                             e.cyc, act, e.v);
                end
            end
        end
    end

    initial begin
        logic dv;
        int   runleft;
        d   = 1'b0;
        rst = 1'b1;
        mq  = 1'b0;
        for (int i = 0; i < S; i++) sm[i] = 1'b0;

        // Reset 3 cycles, then d held high: rise after 6 edges.
        repeat (3) step(1'b0, 1'b1);
        repeat (8) step(1'b1, 1'b0);
        // From q=1, d held low: fall after 6 edges.
        repeat (8) step(1'b0, 1'b0);
        // Short high pulse of 3 cycles is rejected.
        repeat (3) step(1'b1, 1'b0);
        repeat (6) step(1'b0, 1'b0);
        // Reset in CHK_HI with cnt=2, then full latency again.
        repeat (4) step(1'b1, 1'b0);
        step(1'b1, 1'b1);
        repeat (8) step(1'b1, 1'b0);
        // Reset while q=1: q drops, no fall pulse; q re-acquires, then low.
        step(1'b1, 1'b1);
        repeat (8) step(1'b1, 1'b0);
        repeat (8) step(1'b0, 1'b0);
        // Toggle every cycle for 20 cycles, then every 2 and 3 cycles.
        for (int i = 0; i < 20; i++) step(logic'(i % 2), 1'b0);
        for (int i = 0; i < 24; i++) step(logic'((i / 2) % 2), 1'b0);
        for (int i = 0; i < 24; i++) step(logic'((i / 3) % 2), 1'b0);

        // Randomized runs with occasional resets.
        dv      = 1'b0;
        runleft = 0;
        for (int i = 0; i < 1500; i++) begin
            if (runleft == 0) begin
                dv      = ~dv;
                runleft = $urandom_range(1, 8);
            end
            runleft--;
            step(dv, ($urandom_range(0, 199) == 0));
        end

        repeat (2) @(posedge clk);
        #2;
        checks++;
        if (exp_q.size() == 0) begin
            passed++;
        end else begin
            $display("FAIL drain: %0d expectations left, expected 0", exp_q.size());
        end
        $display("%0d/%0d checks passed", passed, checks);
        $finish;
    end

endmodule
